// File: rtl/Ins_def.sv
// Shared types and constants for the memory port arbiter: FSM states,
// transaction owner encoding and the default read latency.
package Ins_def;

    localparam int MEM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Holds MEM_LAT-1, so 1..4 cycles of latency fit in two bits.
    typedef logic [1:0] lat_cnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory signals that the
// arbiter multiplexes; the arbiter uses the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last. Fetch wins the first tie after reset.
module arb_rr2
    import Ins_def::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    owner_t last_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (en) begin
            if (req_if && req_d) begin
                gnt_if = (last_q == OWN_D);
                gnt_d  = (last_q == OWN_IF);
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_D;
        end else if (gnt_if) begin
            last_q <= OWN_IF;
        end else if (gnt_d) begin
            last_q <= OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch port and a load/store port,
// one transaction in flight: grant, issue, wait for read latency, respond.
module mem_port_arbiter
    import Ins_def::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam lat_cnt_t          LAT_LOAD  = lat_cnt_t'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    lat_cnt_t          cnt_q, cnt_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        we_q;
    logic [31:0]       wdata_q;

    logic        gnt_if, gnt_d, accept;
    logic [31:0] resp_data;

    // Gating with reset keeps ready low while reset is held even with requests up.
    arb_rr2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (reset && (state_q == IDLE)),
        .req_if (bus.if_req),
        .req_d  (bus.d_req),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    assign accept       = gnt_if || gnt_d;
    assign bus.if_ready = gnt_if;
    assign bus.d_ready  = gnt_d;
    assign busy         = (state_q != IDLE);

    // Latched fields drive the memory bus directly so they hold between issues.
    assign bus.mem_addr  = addr_q & WORD_MASK;
    assign bus.mem_wdata = wdata_q;
    assign resp_data     = (we_q == 4'b0000) ? bus.mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                owner_q <= gnt_d ? OWN_D : OWN_IF;
                addr_q  <= gnt_d ? bus.d_addr  : bus.if_addr;
                we_q    <= gnt_d ? bus.d_we    : 4'b0000;
                wdata_q <= gnt_d ? bus.d_wdata : 32'h0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'h0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                if ((we_q != 4'b0000) || (MEM_LAT == 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - lat_cnt_t'(1);
                if (cnt_q == lat_cnt_t'(1)) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_IF) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = resp_data;
                end else begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = resp_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each
// behind a small memory model, checked against directed and random scenarios.
module tb_mem_port_arbiter;
    import Ins_def::*;

    localparam int AW = 32;
    localparam logic [31:0] POISON = 32'hDEAD_0BAD;

    logic clk = 1'b0;
    logic reset;
    logic busy1, busy3;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(AW)) b3 ();

    mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(AW)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .busy(busy1));
    mem_port_arbiter #(.MEM_LAT(3), .ADDR_W(AW)) dut3 (
        .clk(clk), .reset(reset), .bus(b3), .busy(busy3));

    // Memory models: word-indexed by addr[7:2]; data returned MEM_LAT cycles
    // after the issue cycle, poison on cycles that follow no issue.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] ref1 [64];
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (b1.mem_en) begin
            for (int l = 0; l < 4; l++)
                if (b1.mem_we[l]) mem1[b1.mem_addr[7:2]][8*l +: 8] <= b1.mem_wdata[8*l +: 8];
            b1.mem_rdata <= mem1[b1.mem_addr[7:2]];
        end else begin
            b1.mem_rdata <= POISON;
        end
    end

    always @(posedge clk) begin
        if (b3.mem_en) begin
            for (int l = 0; l < 4; l++)
                if (b3.mem_we[l]) mem3[b3.mem_addr[7:2]][8*l +: 8] <= b3.mem_wdata[8*l +: 8];
            pipe3[0] <= mem3[b3.mem_addr[7:2]];
        end else begin
            pipe3[0] <= POISON;
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b3.mem_rdata = pipe3[2];

    function automatic logic [137:0] outs1();
        return {b1.if_ready, b1.if_rvalid, b1.if_rdata, b1.d_ready, b1.d_rvalid, b1.d_rdata,
                b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, busy1};
    endfunction

    function automatic logic [137:0] outs3();
        return {b3.if_ready, b3.if_rvalid, b3.if_rdata, b3.d_ready, b3.d_rvalid, b3.d_rdata,
                b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, busy3};
    endfunction

    // Drive just after the rising edge, sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = '0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = '0; b3.d_addr = '0; b3.d_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        b1.if_req = 1'b1; b1.d_req = 1'b1; b1.d_we = 4'hF; b1.d_addr = 32'h44; b1.if_addr = 32'h10;
        b3.if_req = 1'b1; b3.d_req = 1'b1; b3.d_we = 4'hF; b3.d_addr = 32'h44; b3.if_addr = 32'h10;
        #3;
        checks++; if (outs1() !== '0) begin errors++; $display("FAIL reset_outs1 got=%0h exp=0", outs1()); end
        checks++; if (outs3() !== '0) begin errors++; $display("FAIL reset_outs3 got=%0h exp=0", outs3()); end
        cyc(); smp();
        checks++; if (outs1() !== '0) begin errors++; $display("FAIL reset_hold_outs1 got=%0h exp=0", outs1()); end
        cyc();
        reset = 1'b1;
        smp();
        checks++; if ({b1.if_ready, b1.d_ready} !== 2'b10) begin errors++; $display("FAIL first_tie_dut1 got=%b exp=10", {b1.if_ready, b1.d_ready}); end
        checks++; if ({b3.if_ready, b3.d_ready} !== 2'b10) begin errors++; $display("FAIL first_tie_dut3 got=%b exp=10", {b3.if_ready, b3.d_ready}); end
        cyc();
        idle_inputs();
        smp();
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_addr !== 32'h10) begin errors++; $display("FAIL post_reset_issue got=%b/%0h exp=1/10", b1.mem_en, b1.mem_addr); end
        repeat (6) cyc();
    endtask

    task automatic test_fetch();
        mem1[4] <= 32'h0050_0093;
        ref1[4]  = 32'h0050_0093;
        do_reset();
        b1.if_req = 1'b1; b1.if_addr = 32'h10;
        smp();
        checks++; if ({b1.if_ready, b1.d_ready, b1.mem_en, busy1} !== 4'b1000) begin errors++; $display("FAIL fetch_T got=%b exp=1000", {b1.if_ready, b1.d_ready, b1.mem_en, busy1}); end
        cyc();
        b1.if_req = 1'b0;
        smp();
        checks++; if ({b1.mem_en, b1.mem_we, b1.if_ready, busy1, b1.if_rvalid} !== 8'b1_0000_010) begin errors++; $display("FAIL fetch_T1_ctl got=%b exp=10000010", {b1.mem_en, b1.mem_we, b1.if_ready, busy1, b1.if_rvalid}); end
        checks++; if (b1.mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_T1_addr got=%0h exp=10", b1.mem_addr); end
        cyc(); smp();
        checks++; if ({b1.if_rvalid, b1.d_rvalid, b1.mem_en} !== 3'b100) begin errors++; $display("FAIL fetch_T2_ctl got=%b exp=100", {b1.if_rvalid, b1.d_rvalid, b1.mem_en}); end
        checks++; if (b1.if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_T2_data got=%0h exp=500093", b1.if_rdata); end
        cyc(); smp();
        checks++; if ({b1.if_rvalid, busy1} !== 2'b00) begin errors++; $display("FAIL fetch_T3_idle got=%b exp=00", {b1.if_rvalid, busy1}); end
    endtask

    task automatic test_store();
        mem1[8] <= 32'hA5A5_1234;
        ref1[8]  = 32'hA5A5_BEEF;
        do_reset();
        b1.d_req = 1'b1; b1.d_we = 4'b0011; b1.d_addr = 32'h22; b1.d_wdata = 32'hBEEF_BEEF;
        smp();
        checks++; if ({b1.d_ready, b1.if_ready} !== 2'b10) begin errors++; $display("FAIL store_T got=%b exp=10", {b1.d_ready, b1.if_ready}); end
        cyc();
        idle_inputs();
        smp();
        checks++; if ({b1.mem_en, b1.mem_we} !== 5'b1_0011) begin errors++; $display("FAIL store_T1_we got=%b exp=10011", {b1.mem_en, b1.mem_we}); end
        checks++; if (b1.mem_addr !== 32'h20 || b1.mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL store_T1_bus got=%0h/%0h exp=20/beefbeef", b1.mem_addr, b1.mem_wdata); end
        cyc(); smp();
        checks++; if ({b1.d_rvalid, b1.if_rvalid, b1.mem_en, b1.mem_we} !== 7'b10_0_0000) begin errors++; $display("FAIL store_T2_ctl got=%b exp=1000000", {b1.d_rvalid, b1.if_rvalid, b1.mem_en, b1.mem_we}); end
        checks++; if (b1.d_rdata !== 32'h0) begin errors++; $display("FAIL store_T2_rdata got=%0h exp=0", b1.d_rdata); end
        checks++; if (mem1[8] !== 32'hA5A5_BEEF) begin errors++; $display("FAIL store_mem got=%0h exp=a5a5beef", mem1[8]); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic gnt;
        logic own_if;
        do_reset();
        b1.if_req = 1'b1; b1.if_addr = 32'h10;
        b1.d_req = 1'b1; b1.d_we = 4'b0; b1.d_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            gnt    = (c % 3 == 0);
            own_if = ((c / 3) % 2 == 0);
            smp();
            checks++;
            if ({b1.if_ready, b1.d_ready, busy1} !== {gnt && own_if, gnt && !own_if, !gnt}) begin
                errors++;
                $display("FAIL rr_cycle%0d got=%b exp=%b", c, {b1.if_ready, b1.d_ready, busy1}, {gnt && own_if, gnt && !own_if, !gnt});
            end
            if (c % 3 == 2) begin
                checks++;
                if ({b1.if_rvalid, b1.d_rvalid} !== {own_if, !own_if}) begin
                    errors++;
                    $display("FAIL rr_rvalid%0d got=%b exp=%b", c, {b1.if_rvalid, b1.d_rvalid}, {own_if, !own_if});
                end
            end
            cyc();
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_resp_window();
        do_reset();
        b1.d_req = 1'b1; b1.d_we = 4'b0; b1.d_addr = 32'h20;
        smp();
        cyc();
        idle_inputs();
        cyc();
        b1.if_req = 1'b1; b1.if_addr = 32'h10;
        smp();
        checks++; if ({b1.d_rvalid, b1.if_ready} !== 2'b10) begin errors++; $display("FAIL resp_window_resp got=%b exp=10", {b1.d_rvalid, b1.if_ready}); end
        checks++; if (b1.d_rdata !== ref1[8]) begin errors++; $display("FAIL resp_window_data got=%0h exp=%0h", b1.d_rdata, ref1[8]); end
        cyc(); smp();
        checks++; if ({b1.if_ready, busy1} !== 2'b10) begin errors++; $display("FAIL resp_window_idle got=%b exp=10", {b1.if_ready, busy1}); end
        cyc();
        b1.if_req = 1'b0;
        cyc(); smp();
        checks++; if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== ref1[4]) begin errors++; $display("FAIL resp_window_fetch got=%b/%0h exp=1/%0h", b1.if_rvalid, b1.if_rdata, ref1[4]); end
        cyc();
    endtask

    task automatic test_lat3();
        mem3[16] <= 32'h1234_5678;
        do_reset();
        b3.d_req = 1'b1; b3.d_we = 4'b0; b3.d_addr = 32'h40;
        smp();
        checks++; if (b3.d_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready got=%b exp=1", b3.d_ready); end
        cyc();
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            smp();
            checks++;
            if ({b3.mem_en, b3.d_rvalid, busy3} !== {c == 1, c == 4, c <= 4}) begin
                errors++;
                $display("FAIL lat3_T%0d got=%b exp=%b", c, {b3.mem_en, b3.d_rvalid, busy3}, {c == 1, c == 4, c <= 4});
            end
            if (c == 4) begin
                checks++; if (b3.d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL lat3_data got=%0h exp=12345678", b3.d_rdata); end
            end
            cyc();
        end
    endtask

    task automatic test_reset_wait();
        mem3[5] <= 32'hCAFE_0001;
        do_reset();
        b3.d_req = 1'b1; b3.d_we = 4'b0; b3.d_addr = 32'h40;
        smp();
        cyc();
        idle_inputs();
        cyc(); smp();
        checks++; if ({busy3, b3.mem_en} !== 2'b10) begin errors++; $display("FAIL rstwait_in_wait got=%b exp=10", {busy3, b3.mem_en}); end
        #2 reset = 1'b0;
        #1;
        checks++; if (outs3() !== '0) begin errors++; $display("FAIL rstwait_async got=%0h exp=0", outs3()); end
        for (int c = 0; c < 2; c++) begin
            cyc(); smp();
            checks++; if (outs3() !== '0) begin errors++; $display("FAIL rstwait_hold%0d got=%0h exp=0", c, outs3()); end
        end
        cyc();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp();
            checks++; if ({b3.if_rvalid, b3.d_rvalid, busy3} !== 3'b000) begin errors++; $display("FAIL rstwait_quiet%0d got=%b exp=000", c, {b3.if_rvalid, b3.d_rvalid, busy3}); end
            cyc();
        end
        b3.if_req = 1'b1; b3.if_addr = 32'h14;
        smp();
        checks++; if (b3.if_ready !== 1'b1) begin errors++; $display("FAIL rstwait_refetch_ready got=%b exp=1", b3.if_ready); end
        cyc();
        b3.if_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            smp();
            checks++; if (b3.if_rvalid !== (c == 4)) begin errors++; $display("FAIL rstwait_refetch_T%0d got=%b exp=%b", c, b3.if_rvalid, c == 4); end
            if (c == 4) begin
                checks++; if (b3.if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rstwait_refetch_data got=%0h exp=cafe0001", b3.if_rdata); end
            end
            cyc();
        end
    endtask

    task automatic test_random();
        int unsigned pat;
        logic [31:0] ia, da, wd, ea;
        logic [3:0]  dwe, ewe;
        logic [5:0]  idx;
        owner_t      own, last;
        do_reset();
        last = OWN_D;
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(1, 3);
            ia  = 32'($urandom_range(0, 255));
            da  = 32'($urandom_range(0, 255));
            dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            wd  = $urandom;
            b1.if_req = pat[0]; b1.if_addr = ia;
            b1.d_req = pat[1]; b1.d_addr = da; b1.d_we = dwe; b1.d_wdata = wd;
            if (pat == 3) own = (last == OWN_D) ? OWN_IF : OWN_D;
            else          own = (pat == 1) ? OWN_IF : OWN_D;
            last = own;
            ea  = ((own == OWN_IF) ? ia : da) & 32'hFFFF_FFFC;
            ewe = (own == OWN_IF) ? 4'b0000 : dwe;
            idx = ea[7:2];
            smp();
            checks++; if ({b1.if_ready, b1.d_ready} !== {own == OWN_IF, own == OWN_D}) begin errors++; $display("FAIL rnd%0d_grant got=%b exp=%b", n, {b1.if_ready, b1.d_ready}, {own == OWN_IF, own == OWN_D}); end
            cyc();
            idle_inputs();
            smp();
            checks++; if ({b1.mem_en, b1.mem_we, b1.mem_addr} !== {1'b1, ewe, ea}) begin errors++; $display("FAIL rnd%0d_issue got=%0h exp=%0h", n, {b1.mem_en, b1.mem_we, b1.mem_addr}, {1'b1, ewe, ea}); end
            if (ewe != 4'b0000) begin
                checks++; if (b1.mem_wdata !== wd) begin errors++; $display("FAIL rnd%0d_wdata got=%0h exp=%0h", n, b1.mem_wdata, wd); end
            end
            cyc(); smp();
            checks++; if ({b1.if_rvalid, b1.d_rvalid} !== {own == OWN_IF, own == OWN_D}) begin errors++; $display("FAIL rnd%0d_rvalid got=%b exp=%b", n, {b1.if_rvalid, b1.d_rvalid}, {own == OWN_IF, own == OWN_D}); end
            checks++;
            if (((own == OWN_IF) ? b1.if_rdata : b1.d_rdata) !== ((ewe == 4'b0000) ? ref1[idx] : 32'h0)) begin
                errors++;
                $display("FAIL rnd%0d_rdata got=%0h exp=%0h", n, (own == OWN_IF) ? b1.if_rdata : b1.d_rdata, (ewe == 4'b0000) ? ref1[idx] : 32'h0);
            end
            for (int l = 0; l < 4; l++)
                if (ewe[l]) ref1[idx][8*l +: 8] = wd[8*l +: 8];
            cyc();
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem1[i] <= v;
            ref1[i]  = v;
            mem3[i] <= $urandom;
        end
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_resp_window();
        test_lat3();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles from the issue cycle; legal range 1..4.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  the single clock; all flops on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  input  1  fetch request.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port if_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch data valid, one-cycle pulse.
REQ-009 SHALL have port if_rdata  output  32  fetch data.
REQ-010 SHALL have port d_req  input  1  load/store request.
REQ-011 SHALL have port d_we  input  4  byte write enables; 0 means load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  32  store data, pre-replicated across lanes.
REQ-014 SHALL have port d_ready  output  1  data request accepted this cycle.
REQ-015 SHALL have port d_rvalid  output  1  load data valid or store complete, one-cycle pulse.
REQ-016 SHALL have port d_rdata  output  32  load data; 0 on store completion.
REQ-017 SHALL have port mem_en, mem_we[4], mem_addr[ADDR_W], mem_wdata[32] as outputs, and mem_rdata[32] as input, forming a single-port unified memory.
REQ-018 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: when any request is pending, SHALL grant exactly one request, with the combinational ready high in the same cycle (cycle T); SHALL latch owner, addr, we and wdata; next state is ISSUE.
REQ-021 Arbitration: if only one request is pending, SHALL grant it; if both are pending, SHALL grant the requester not granted last (round-robin); the last-grant flag resets to "data", so fetch wins the first tie.
REQ-022 ISSUE (cycle T+1): SHALL drive mem_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_we=latched we, and mem_wdata=latched wdata.
REQ-023 ISSUE with we!=0: SHALL go to RESP next cycle.
REQ-024 ISSUE with a read: if MEM_LAT==1, SHALL go to RESP; otherwise SHALL load the counter with MEM_LAT-1 and go to WAIT.
REQ-025 WAIT: SHALL keep mem_en=0 and decrement the counter; when the counter equals 1, SHALL go to RESP.
REQ-026 RESP: SHALL pulse the owner's rvalid for one cycle, with rdata=mem_rdata for a read and 0 for a write, and the non-owner's rvalid=0; next state is IDLE.
REQ-027 Read latency from accept to rvalid SHALL be MEM_LAT+1 cycles; write latency SHALL be 2 cycles.
REQ-028 Both ready outputs SHALL be 0 outside IDLE; requesters hold req/addr/we/wdata stable until ready, and may change them the cycle after ready.
REQ-029 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their latched values.
REQ-030 Address bits [1:0] SHALL be ignored; byte-lane selection belongs to the requester's we/wdata.
REQ-031 A request deasserted before being granted SHALL be dropped without side effects.
REQ-032 The block SHALL handle at most one transaction in flight; there is no queuing.

Reset
REQ-033 While reset=0, SHALL asynchronously force state=IDLE, counter=0, last-grant=data, and latched fields=0.
REQ-034 While reset=0, all outputs (ready, rvalid, rdata, mem_*, busy) SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction with no rvalid; the requester reissues after reset.
REQ-036 SHALL permit a grant on the first clk edge after reset deasserts.

Structure
REQ-037 The enum arb_state_t {IDLE, ISSUE, WAIT, RESP}, the enum owner_t {OWN_IF, OWN_D} and the MEM_LAT default constant SHALL reside in the shared package Ins_def.
REQ-038 The two-way round-robin grant logic, including the last-grant flop, SHALL be a sub-module arb_rr2.

Verification
REQ-039 Single fetch with MEM_LAT=1, if_addr=0x10, mem[0x10]=0x00500093: SHALL give if_ready at T, mem_en at T+1, and if_rvalid with if_rdata=0x00500093 at T+2.
REQ-040 Store with d_we=4'b0011, d_addr=0x22, d_wdata=0xBEEFBEEF: SHALL give mem_addr=0x20 and mem_we=0011 at T+1, d_rvalid at T+2 with d_rdata=0, and mem[0x20][15:0]=0xBEEF.
REQ-041 Simultaneous if_req and d_req held continuously after reset: SHALL give grants alternating IF, D, IF, D with neither starved, and busy low only in the grant cycles.
REQ-042 With MEM_LAT=3, load from 0x40=0x12345678: SHALL give d_rvalid exactly 4 cycles after d_ready, with mem_en high only at T+1.
REQ-043 reset pulled low during WAIT: SHALL return all outputs to 0 immediately with no rvalid; after release, a re-requested fetch completes normally.
REQ-044 if_req raised while a data transaction is in RESP: SHALL give if_ready=0 in RESP, then if_ready=1 in the following IDLE cycle.
